// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART: one status/data word, bus-driven TX, buffered RX.
// state | meaning: IDLE line idle / START start bit / DATA 8 data bits / STOP stop bit
module uart_ctrl #(
    parameter int clks_per_bit = 216
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    input  logic        uart_rx,
    output logic        uart_tx
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_TC  = 16'(clks_per_bit);
    localparam logic [15:0] HALF_TC = 16'(clks_per_bit / 2);

    state_t      tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        wr_pend;
    logic [7:0]  wr_byte;

    state_t      rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        overrun;
    logic        rx_s1;
    logic        rx_s2;

    logic        rd_req;
    logic        wr_req;
    logic        wr_go;
    logic        tx_busy;
    logic [7:0]  wr_sel;
    logic        unused_bits;

    assign rd_req  = uart_valid && (uart_wstrb == 4'b0000);
    assign wr_req  = uart_valid && (uart_wstrb != 4'b0000);
    assign tx_busy = (tx_state != IDLE);
    assign wr_go   = (tx_state == IDLE) && (wr_pend || wr_req);
    assign wr_sel  = wr_pend ? wr_byte : uart_wdata[7:0];
    assign unused_bits = ^{uart_instr, uart_addr, uart_wdata[31:8]};

    // Bus responder and TX FSM share acceptance of the write.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state   <= IDLE;
            tx_cnt     <= 16'd0;
            tx_bit     <= 3'd0;
            tx_shift   <= 8'd0;
            wr_pend    <= 1'b0;
            wr_byte    <= 8'd0;
            uart_tx    <= 1'b1;
            uart_ready <= 1'b0;
            uart_rdata <= 32'd0;
        end else begin
            uart_ready <= 1'b0;
            uart_rdata <= 32'd0;
            if (rd_req) begin
                uart_ready <= 1'b1;
                uart_rdata <= {21'd0, overrun, tx_busy, rx_valid, rx_byte};
            end
            if (wr_req && !wr_go) begin
                wr_pend <= 1'b1;
                wr_byte <= uart_wdata[7:0];
            end
            case (tx_state)
                IDLE: begin
                    if (wr_go) begin
                        tx_state   <= START;
                        tx_cnt     <= BIT_TC;
                        tx_shift   <= wr_sel;
                        uart_tx    <= 1'b0;
                        uart_ready <= 1'b1;
                        wr_pend    <= 1'b0;
                    end
                end
                START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= DATA;
                        tx_cnt   <= BIT_TC;
                        tx_bit   <= 3'd0;
                        uart_tx  <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= BIT_TC;
                        if (tx_bit == 3'd7) begin
                            tx_state <= STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            uart_tx  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
            rx_byte  <= 8'd0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            if (rd_req) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            case (rx_state)
                IDLE: begin
                    if (!rx_s2) begin
                        rx_state <= START;
                        rx_cnt   <= HALF_TC;
                    end
                end
                START: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= rx_s2 ? IDLE : DATA;
                        rx_cnt   <= BIT_TC;
                        rx_bit   <= 3'd0;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= BIT_TC;
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= IDLE;
                        // A store in the same cycle as a read beats the read's clear.
                        if (rx_s2) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                            if (rd_req) begin
                                overrun <= overrun;
                            end else if (rx_valid) begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: table-driven TX/RX vectors plus a read-data scoreboard.
module tb_uart_ctrl;
    localparam int CPB = 4;
    localparam int BIT_CYC = CPB + 1;

    logic        clock;
    logic        reset;
    logic        uart_valid;
    logic        uart_instr;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_rx;
    logic        uart_tx;
    logic        rx_drv;
    logic        loopback;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0]  rx_byte;
        logic [31:0] first_rd;
        logic [31:0] second_rd;
    } rx_vec_t;

    rx_vec_t     rx_tab[4];
    logic [7:0]  tx_tab[4];

    assign uart_rx = loopback ? uart_tx : rx_drv;

    uart_ctrl #(.clks_per_bit(CPB)) dut (
        .clock(clock),
        .reset(reset),
        .uart_valid(uart_valid),
        .uart_instr(uart_instr),
        .uart_addr(uart_addr),
        .uart_wdata(uart_wdata),
        .uart_wstrb(uart_wstrb),
        .uart_rdata(uart_rdata),
        .uart_ready(uart_ready),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Scoreboard: every ready pulse consumes one expected rdata.
    always @(negedge clock) begin
        if (uart_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: got ready=1 expected no pending request at %0t", $time);
            end else begin
                check("rdata", uart_rdata, exp_q.pop_front());
            end
        end else begin
            check("rdata_idle", uart_rdata, 32'd0);
        end
    end

    task automatic bus_read(input logic [31:0] exp);
        exp_q.push_back(exp);
        uart_wstrb = 4'b0000;
        uart_valid = 1'b1;
        @(negedge clock);
        uart_valid = 1'b0;
        check("read_latency", {31'd0, uart_ready}, 32'd1);
    endtask

    task automatic bus_write(input logic [7:0] b, output int lat);
        exp_q.push_back(32'd0);
        uart_wdata = {24'hABCDE0, b};
        uart_wstrb = 4'b0001;
        uart_valid = 1'b1;
        @(negedge clock);
        uart_valid = 1'b0;
        lat = 1;
        while (!uart_ready && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        if (!uart_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_timeout: got no ready after %0d cycles expected ready", lat);
        end
        uart_wstrb = 4'b0000;
        uart_wdata = 32'd0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        for (int k = 0; k < 10; k++) begin
            rx_drv = frame_bit(b, k);
            repeat (BIT_CYC) @(negedge clock);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int lat;
        rx_tab[0] = '{8'h3C, 32'h0000013C, 32'h0000003C};
        rx_tab[1] = '{8'h00, 32'h00000100, 32'h00000000};
        rx_tab[2] = '{8'hFF, 32'h000001FF, 32'h000000FF};
        rx_tab[3] = '{8'h81, 32'h00000181, 32'h00000081};
        tx_tab[0] = 8'hA5;
        tx_tab[1] = 8'h00;
        tx_tab[2] = 8'hFF;
        tx_tab[3] = 8'h5A;

        reset = 1'b1;
        uart_valid = 1'b0;
        uart_instr = 1'b0;
        uart_addr = 32'h01000000;
        uart_wdata = 32'd0;
        uart_wstrb = 4'b0000;
        rx_drv = 1'b1;
        loopback = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            check("reset_tx", {31'd0, uart_tx}, 32'd1);
            check("reset_ready", {31'd0, uart_ready}, 32'd0);
            @(negedge clock);
        end
        bus_read(32'h00000000);

        for (int i = 0; i < 4; i++) begin
            bus_write(tx_tab[i], lat);
            check("write_latency", lat, 1);
            for (int c = 0; c < 10 * BIT_CYC; c++) begin
                check("tx_frame", {31'd0, uart_tx}, {31'd0, frame_bit(tx_tab[i], c / BIT_CYC)});
                @(negedge clock);
            end
            check("tx_idle_after", {31'd0, uart_tx}, 32'd1);
            bus_read(32'h00000000);
        end

        bus_write(8'hC3, lat);
        check("first_write_latency", lat, 1);
        repeat (2) @(negedge clock);
        bus_write(8'h3C, lat);
        check("queued_write_latency", lat, 10 * BIT_CYC - 1);
        check("queued_start", {31'd0, uart_tx}, 32'd0);
        bus_read(32'h00000200);
        repeat (12 * BIT_CYC) @(negedge clock);
        bus_read(32'h00000000);

        for (int i = 0; i < 4; i++) begin
            send_rx(rx_tab[i].rx_byte);
            repeat (2) @(negedge clock);
            bus_read(rx_tab[i].first_rd);
            bus_read(rx_tab[i].second_rd);
        end

        send_rx(8'h11);
        send_rx(8'h22);
        repeat (2) @(negedge clock);
        bus_read(32'h00000522);
        bus_read(32'h00000022);
        rx_drv = 1'b0;
        repeat (2) @(negedge clock);
        rx_drv = 1'b1;
        repeat (12 * BIT_CYC) @(negedge clock);
        bus_read(32'h00000022);

        loopback = 1'b1;
        bus_write(8'h5A, lat);
        check("loop_write_latency", lat, 1);
        repeat (4 * BIT_CYC) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset_midframe_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_midframe_ready", {31'd0, uart_ready}, 32'd0);
        reset = 1'b0;
        repeat (12 * BIT_CYC) @(negedge clock);
        bus_read(32'h00000000);
        bus_write(8'h5A, lat);
        check("loop_write2_latency", lat, 1);
        repeat (12 * BIT_CYC) @(negedge clock);
        bus_read(32'h0000015A);
        bus_read(32'h0000005A);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
